spi_host: RTL and testbench

SPI_HOST -- requirements
Module: spi_host

---
 rtl/kolibri_pkg.sv | 43 ++++
 rtl/spi_baud.sv | 35 +++
 rtl/spi_host.sv | 199 +++++++++++++++++++
 tb/tb_spi_host.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kolibri_pkg.sv
// kolibri_pkg: definitions shared by the SPI host block and its sub-modules.
//   - CPU register offsets within the $FE30-$FE33 window
//   - STATUS register bit positions and a STATUS byte builder
//   - reset constants for the DATA and DIV registers
//   - SPI transfer FSM state encoding
package kolibri_pkg;

    // Register offsets (A[1:0])
    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_CTRL = 2'd1;   // CTRL on write, STATUS on read
    localparam logic [1:0] REG_DIV  = 2'd2;
    localparam logic [1:0] REG_RSVD = 2'd3;

    // STATUS bit positions
    localparam int STAT_BUSY = 7;
    localparam int STAT_OVR  = 6;
    localparam int STAT_SS1  = 1;
    localparam int STAT_SS0  = 0;

    // Reset values: DIV=59 gives 400 kHz SCLK from 48 MHz
    localparam logic [7:0] DIV_RESET  = 8'd59;
    localparam logic [7:0] DATA_RESET = 8'hFF;

    // Transfer FSM: LOW/HIGH name the current SCLK level
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } spiState_t;

    // Assemble the STATUS byte; unused bits read as zero
    function automatic logic [7:0] statusByte(input logic busy, input logic ovr,
                                              input logic [1:0] ss);
        logic [7:0] s;
        s            = 8'h00;
        s[STAT_BUSY] = busy;
        s[STAT_OVR]  = ovr;
        s[STAT_SS1]  = ss[1];
        s[STAT_SS0]  = ss[0];
        return s;
    endfunction

endpackage

// File: rtl/spi_baud.sv
// spi_baud: SCLK half-period timer.
//   clk   - master clock
//   rst   - asynchronous active-high reset
//   clear - restart the half-period from zero (used at transfer start)
//   div   - half-period length minus one (1..256 cycles)
//   tick  - high for one cycle at the end of every div+1 cycle period
module spi_baud
    import kolibri_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic [7:0] div,
    output logic       tick
);

    logic [7:0] cnt_r;

    // ">=" so a DIV lowered below the running count cannot cause a 256-cycle wrap
    assign tick = (cnt_r >= div);

    // Half-period counter: 0..div, restarted by clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 8'd0;
        end else if (clear) begin
            cnt_r <= 8'd0;
        end else if (tick) begin
            cnt_r <= 8'd0;
        end else begin
            cnt_r <= cnt_r + 8'd1;
        end
    end

endmodule

// File: rtl/spi_host.sv
// spi_host: 6309 bus-attached SPI master for two SD card slots (mode 0, MSB first).
//   MHZ48        - master clock          RES   - async active-high reset
//   nSPICS       - register select (low) nE    - bus strobe, low = data phase
//   RW           - 1 read / 0 write      A     - register offset
//   DIN / DOUT   - CPU write / read data DOE   - read data output enable
//   SCLK / MOSI  - SPI clock and data    MISO  - SPI data in
//   nSD0 / nSD1  - SD card chip selects (active-low)
module spi_host
    import kolibri_pkg::*;
(
    input  logic       MHZ48,
    input  logic       RES,
    input  logic       nSPICS,
    input  logic       nE,
    input  logic       RW,
    input  logic [1:0] A,
    input  logic [7:0] DIN,
    output logic [7:0] DOUT,
    output logic       DOE,
    output logic       SCLK,
    output logic       MOSI,
    input  logic       MISO,
    output logic       nSD0,
    output logic       nSD1
);

    spiState_t  state_r;
    logic       nE_r;
    logic       wrPend_r;
    logic [1:0] wrAddr_r;
    logic [7:0] wrData_r;
    logic       busy_r;
    logic       ovr_r;
    logic [7:0] shift_r;
    logic [2:0] bitCnt_r;
    logic [7:0] data_r;
    logic [7:0] div_r;
    logic [1:0] ss_r;
    logic [7:0] readMux_s;

    logic wrDetect_s;
    logic rdStatusEnd_s;
    logic startXfer_s;
    logic wrAccept_s;
    logic wrBlocked_s;
    logic tick_s;

    // End of a bus cycle is the rising edge of nE seen against its registered copy
    assign wrDetect_s    = ~nE_r & nE & ~nSPICS & ~RW;
    assign rdStatusEnd_s = ~nE_r & nE & ~nSPICS & RW & (A == REG_CTRL);

    // busy_r is still 1 in the cycle the transfer ends, so a coinciding write is refused
    assign wrAccept_s  = wrPend_r & ~busy_r;
    assign wrBlocked_s = wrPend_r & busy_r & (wrAddr_r != REG_RSVD);
    assign startXfer_s = wrAccept_s & (wrAddr_r == REG_DATA) & (state_r == IDLE);

    spi_baud u_baud (
        .clk   (MHZ48),
        .rst   (RES),
        .clear (startXfer_s),
        .div   (div_r),
        .tick  (tick_s)
    );

    // Capture the write at the nE rising edge; it is committed one cycle later
    always_ff @(posedge MHZ48 or posedge RES) begin
        if (RES) begin
            nE_r     <= 1'b1;
            wrPend_r <= 1'b0;
            wrAddr_r <= 2'd0;
            wrData_r <= 8'h00;
        end else begin
            nE_r     <= nE;
            wrPend_r <= wrDetect_s;
            if (wrDetect_s) begin
                wrAddr_r <= A;
                wrData_r <= DIN;
            end else begin
                wrAddr_r <= wrAddr_r;
                wrData_r <= wrData_r;
            end
        end
    end

    // Register file: CTRL (selects), DIV, and the sticky overrun flag
    always_ff @(posedge MHZ48 or posedge RES) begin
        if (RES) begin
            ss_r  <= 2'b00;
            nSD0  <= 1'b1;
            nSD1  <= 1'b1;
            div_r <= DIV_RESET;
            ovr_r <= 1'b0;
        end else begin
            if (wrAccept_s && (wrAddr_r == REG_CTRL)) begin
                ss_r <= wrData_r[1:0];
                nSD0 <= ~wrData_r[0];
                nSD1 <= ~wrData_r[1];
            end else begin
                ss_r <= ss_r;
                nSD0 <= nSD0;
                nSD1 <= nSD1;
            end
            if (wrAccept_s && (wrAddr_r == REG_DIV)) begin
                div_r <= wrData_r;
            end else begin
                div_r <= div_r;
            end
            // Setting wins over clearing should both ever coincide
            if (wrBlocked_s) begin
                ovr_r <= 1'b1;
            end else if (rdStatusEnd_s) begin
                ovr_r <= 1'b0;
            end else begin
                ovr_r <= ovr_r;
            end
        end
    end

    // Transfer FSM with registered SCLK/MOSI/BUSY and the received-byte register
    always_ff @(posedge MHZ48 or posedge RES) begin
        if (RES) begin
            state_r  <= IDLE;
            SCLK     <= 1'b0;
            MOSI     <= 1'b1;
            busy_r   <= 1'b0;
            shift_r  <= 8'h00;
            bitCnt_r <= 3'd0;
            data_r   <= DATA_RESET;
        end else begin
            case (state_r)
                IDLE: begin
                    if (startXfer_s) begin
                        state_r  <= LOW;
                        busy_r   <= 1'b1;
                        shift_r  <= wrData_r;
                        MOSI     <= wrData_r[7];
                        bitCnt_r <= 3'd0;
                    end else begin
                        state_r  <= IDLE;
                    end
                    SCLK <= 1'b0;
                end
                LOW: begin
                    if (tick_s) begin
                        // Rising SCLK: sample MISO; shift_r[7] becomes the next bit out
                        state_r <= HIGH;
                        SCLK    <= 1'b1;
                        shift_r <= {shift_r[6:0], MISO};
                    end else begin
                        state_r <= LOW;
                    end
                end
                HIGH: begin
                    if (tick_s) begin
                        SCLK <= 1'b0;
                        if (bitCnt_r == 3'd7) begin
                            state_r <= IDLE;
                            MOSI    <= 1'b1;
                            busy_r  <= 1'b0;
                            data_r  <= shift_r;
                        end else begin
                            state_r  <= LOW;
                            MOSI     <= shift_r[7];
                            bitCnt_r <= bitCnt_r + 3'd1;
                        end
                    end else begin
                        state_r <= HIGH;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    SCLK    <= 1'b0;
                    MOSI    <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign DOE = ~nSPICS & ~nE & RW;

    // Combinational read mux; DOUT idles at zero outside a read data phase
    always_comb begin
        readMux_s = 8'h00;
        case (A)
            REG_DATA: readMux_s = data_r;
            REG_CTRL: readMux_s = statusByte(busy_r, ovr_r, ss_r);
            REG_DIV:  readMux_s = div_r;
            REG_RSVD: readMux_s = 8'h00;
            default:  readMux_s = 8'h00;
        endcase
        if (DOE) begin
            DOUT = readMux_s;
        end else begin
            DOUT = 8'h00;
        end
    end

endmodule

// File: tb/tb_spi_host.sv
// tb_spi_host: directed self-checking bench for spi_host.
module tb_spi_host;
    import kolibri_pkg::*;

    logic       MHZ48 = 1'b0;
    logic       RES;
    logic       nSPICS;
    logic       nE;
    logic       RW;
    logic [1:0] A;
    logic [7:0] DIN;
    logic [7:0] DOUT;
    logic       DOE;
    logic       SCLK;
    logic       MOSI;
    logic       MISO;
    logic       nSD0;
    logic       nSD1;
    logic       misoLoop;

    int checks   = 0;
    int failures = 0;

    // SPI monitor: MOSI captured on every SCLK rising edge
    logic [7:0] monByte  = 8'h00;
    int         monRises = 0;

    assign MISO = misoLoop ? MOSI : 1'b0;

    always #5 MHZ48 = ~MHZ48;

    always @(posedge SCLK) begin
        monByte  <= {monByte[6:0], MOSI};
        monRises <= monRises + 1;
    end

    spi_host dut (
        .MHZ48 (MHZ48),
        .RES   (RES),
        .nSPICS(nSPICS),
        .nE    (nE),
        .RW    (RW),
        .A     (A),
        .DIN   (DIN),
        .DOUT  (DOUT),
        .DOE   (DOE),
        .SCLK  (SCLK),
        .MOSI  (MOSI),
        .MISO  (MISO),
        .nSD0  (nSD0),
        .nSD1  (nSD1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full write cycle; commit happens at the first rising clock after return
    task automatic cpuWrite(input logic [1:0] addr, input logic [7:0] data);
        @(negedge MHZ48);
        nSPICS = 1'b0; RW = 1'b0; A = addr; DIN = data; nE = 1'b1;
        @(negedge MHZ48);
        nE = 1'b0;
        @(negedge MHZ48);
        nE = 1'b1;
        @(negedge MHZ48);
        nSPICS = 1'b1; RW = 1'b1;
    endtask

    // Full read cycle; ends with an nE rising edge (clears OVR on STATUS)
    task automatic cpuRead(input logic [1:0] addr, output logic [7:0] data);
        @(negedge MHZ48);
        nSPICS = 1'b0; RW = 1'b1; A = addr; nE = 1'b0;
        @(negedge MHZ48);
        #1 data = DOUT;
        nE = 1'b1;
        @(negedge MHZ48);
        nSPICS = 1'b1;
    endtask

    // Hold a read data phase open without ever completing it
    task automatic peekOpen(input logic [1:0] addr);
        nSPICS = 1'b0; RW = 1'b1; nE = 1'b0; A = addr;
    endtask

    // Deselect together with nE rising so no bus-cycle end is seen
    task automatic peekClose();
        nSPICS = 1'b1; nE = 1'b1;
    endtask

    // Watch STATUS.BUSY each cycle; report busy length and SCLK level run lengths
    task automatic measureBusy(output int busyCyc, output int runCnt, output int runMin,
                               output int runMax, output logic done);
        logic seen;
        logic prevS;
        int   runLen;
        busyCyc = 0; runCnt = 0; runMin = 9999; runMax = 0;
        done = 1'b0; seen = 1'b0; prevS = 1'b0; runLen = 0;
        peekOpen(REG_CTRL);
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge MHZ48);
            #1;
            if (DOUT[STAT_BUSY]) begin
                seen = 1'b1;
                busyCyc++;
                if (SCLK == prevS) begin
                    runLen++;
                end else begin
                    runCnt++;
                    if (runLen < runMin) runMin = runLen;
                    if (runLen > runMax) runMax = runLen;
                    runLen = 1;
                    prevS  = SCLK;
                end
            end else if (seen) begin
                runCnt++;
                if (runLen < runMin) runMin = runLen;
                if (runLen > runMax) runMax = runLen;
                done = 1'b1;
            end
        end
        peekClose();
    endtask

    initial begin
        logic [7:0] rd;
        int         busyCyc, runCnt, runMin, runMax, base;
        logic       done;

        RES = 1'b1; nSPICS = 1'b1; nE = 1'b1; RW = 1'b1; A = 2'd0; DIN = 8'h00;
        misoLoop = 1'b1;
        repeat (3) @(negedge MHZ48);
        RES = 1'b0;
        @(negedge MHZ48);

        // Reset state
        check("dout_idle", DOUT, 8'h00);
        check("doe_idle", DOE, 1'b0);
        peekOpen(REG_CTRL);
        #1 check("rst_status", DOUT, 8'h00);
        check("doe_read", DOE, 1'b1);
        A = REG_DIV;
        #1 check("rst_div", DOUT, 8'd59);
        A = REG_DATA;
        #1 check("rst_data", DOUT, 8'hFF);
        peekClose();
        check("rst_nsd0", nSD0, 1'b1);
        check("rst_nsd1", nSD1, 1'b1);
        check("rst_sclk", SCLK, 1'b0);
        check("rst_mosi", MOSI, 1'b1);

        // Loopback transfer at DIV=0
        cpuWrite(REG_CTRL, 8'h01);
        cpuWrite(REG_DIV, 8'h00);
        misoLoop = 1'b1;
        base = monRises;
        cpuWrite(REG_DATA, 8'hA5);
        measureBusy(busyCyc, runCnt, runMin, runMax, done);
        check("a5_done", done, 1'b1);
        check("a5_busy_cycles", busyCyc, 16);
        check("a5_runs", runCnt, 16);
        check("a5_run_max", runMax, 1);
        check("a5_rises", monRises - base, 8);
        check("a5_mosi_byte", monByte, 8'hA5);
        check("a5_mosi_idle", MOSI, 1'b1);
        cpuRead(REG_DATA, rd);
        check("a5_data", rd, 8'hA5);
        check("a5_nsd0", nSD0, 1'b0);
        check("a5_nsd1", nSD1, 1'b1);
        cpuRead(REG_CTRL, rd);
        check("a5_status", rd, 8'h01);

        // DIV=2, MISO tied low
        cpuWrite(REG_DIV, 8'd2);
        misoLoop = 1'b0;
        cpuWrite(REG_DATA, 8'hFF);
        measureBusy(busyCyc, runCnt, runMin, runMax, done);
        check("ff_done", done, 1'b1);
        check("ff_busy_cycles", busyCyc, 48);
        check("ff_runs", runCnt, 16);
        check("ff_run_min", runMin, 3);
        check("ff_run_max", runMax, 3);
        cpuRead(REG_DATA, rd);
        check("ff_data", rd, 8'h00);

        // Write while busy: ignored, OVR sticky until a STATUS read ends
        misoLoop = 1'b1;
        base = monRises;
        cpuWrite(REG_DATA, 8'h3C);
        cpuWrite(REG_DATA, 8'h11);
        repeat (60) @(negedge MHZ48);
        check("ovr_rises", monRises - base, 8);
        check("ovr_mosi_byte", monByte, 8'h3C);
        cpuRead(REG_CTRL, rd);
        check("ovr_status1", rd, 8'h41);
        cpuRead(REG_CTRL, rd);
        check("ovr_status2", rd, 8'h01);
        cpuRead(REG_DATA, rd);
        check("ovr_data", rd, 8'h3C);

        // Reset in the middle of a transfer
        base = monRises;
        cpuWrite(REG_DATA, 8'hC3);
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge MHZ48);
            if (monRises - base >= 4) done = 1'b1;
        end
        check("rst_mid_reached", done, 1'b1);
        RES = 1'b1;
        #1;
        check("rst_mid_sclk", SCLK, 1'b0);
        check("rst_mid_mosi", MOSI, 1'b1);
        check("rst_mid_nsd0", nSD0, 1'b1);
        peekOpen(REG_CTRL);
        #1 check("rst_mid_status", DOUT, 8'h00);
        peekClose();
        @(negedge MHZ48);
        RES = 1'b0;
        cpuRead(REG_DATA, rd);
        check("rst_mid_data", rd, 8'hFF);
        repeat (40) @(negedge MHZ48);
        check("rst_mid_rises", monRises - base, 4);
        check("rst_mid_sclk_idle", SCLK, 1'b0);

        // Write commit landing exactly on the cycle BUSY falls
        cpuWrite(REG_DIV, 8'h00);
        misoLoop = 1'b1;
        base = monRises;
        cpuWrite(REG_DATA, 8'h5A);
        repeat (12) @(negedge MHZ48);
        cpuWrite(REG_DATA, 8'h11);
        repeat (40) @(negedge MHZ48);
        check("edge_rises", monRises - base, 8);
        check("edge_mosi_byte", monByte, 8'h5A);
        peekOpen(REG_CTRL);
        #1 check("edge_status", DOUT, 8'h40);
        peekClose();
        cpuRead(REG_DATA, rd);
        check("edge_data", rd, 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
